// File: rtl/tcdm_verilator_if.sv
// Bundled TCDM bus for MP ports: request/grant phase plus registered response.
// Latency: none (wires only).
// Backpressure: gnt returned by the slave; the master holds req until granted.
//
// Signals (one slot per port, index i in [0, MP)):
//   req[i]     master->slave  access request
//   add[i]     master->slave  byte address, bits [1:0] ignored
//   wen[i]     master->slave  1 = read, 0 = write
//   be[i]      master->slave  byte enables for writes
//   data[i]    master->slave  write data
//   gnt[i]     slave->master  grant, same cycle as req
//   r_data[i]  slave->master  response data, one cycle after grant
//   r_valid[i] slave->master  response valid, one cycle after grant
interface tcdm_verilator_if #(
  parameter int unsigned MP = 1
);
  logic [MP-1:0]       req;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] data;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] r_data;
  logic [MP-1:0]       r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/tcdm_verilator.sv
// Multi-port single-cycle TCDM memory model sharing one little-endian byte array.
// Latency: grant combinational in the request cycle; r_valid/r_data registered, one cycle later.
// Backpressure: none; every request is granted while enable_i is high, one access per port per cycle.
//
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset (clears responses only, never the array)
//   enable_i  global enable; low means no port is granted
//   tcdm      slave side of tcdm_verilator_if, MP ports
//
// Optional build macro TCDM_VERILATOR_OOB_CHECK_EN: accesses outside
// [BASE_ADDR, BASE_ADDR+MEMORY_SIZE) are still granted, report $error,
// drop writes and return 32'hDEADBEEF. Without it the offset wraps.
module tcdm_verilator #(
  parameter int unsigned MP          = 1,
  parameter int unsigned MEMORY_SIZE = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  tcdm_verilator_if.slave tcdm
);

  localparam int unsigned AW        = $clog2(MEMORY_SIZE);
  localparam logic [31:0] MEM_BYTES = 32'(MEMORY_SIZE);

  // Preloaded by the bench; deliberately left out of reset.
  logic [7:0] memory [MEMORY_SIZE];

  logic [MP-1:0]         w_gnt;
  logic [MP-1:0][31:0]   w_rel;
  logic [MP-1:0][AW-1:0] w_off;
  logic [MP-1:0][31:0]   w_rdata;
  logic [MP-1:0]         w_drop;

  logic [MP-1:0]         r_valid;
  logic [MP-1:0][31:0]   r_rdata;

  assign w_gnt = tcdm.req & {MP{enable_i}};

  // Address decode and pre-write read of the addressed word.
  always_comb begin
    w_rel   = '0;
    w_off   = '0;
    w_rdata = '0;
    for (int i = 0; i < MP; i++) begin
      w_rel[i] = tcdm.add[i] - BASE_ADDR;
      // MEMORY_SIZE is a multiple of 4, so aligning before the modulo keeps
      // all four bytes of the word inside the array.
      w_off[i] = AW'((w_rel[i] & 32'hFFFF_FFFC) % MEM_BYTES);
      for (int k = 0; k < 4; k++) begin
        w_rdata[i][8*k +: 8] = memory[w_off[i] + AW'(k)];
      end
    end
  end

`ifdef TCDM_VERILATOR_OOB_CHECK_EN
  logic [MP-1:0] w_oob;

  // Unsigned wrap of add-BASE_ADDR also catches addresses below the base.
  always_comb begin
    w_oob = '0;
    for (int i = 0; i < MP; i++) begin
      w_oob[i] = (w_rel[i] >= MEM_BYTES);
    end
  end

  assign w_drop = w_oob;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (w_gnt[i] && w_oob[i]) begin
        $error("tcdm_verilator: port %0d out-of-range address 0x%08h", i, tcdm.add[i]);
      end
    end
  end
`else
  assign w_drop = '0;
`endif

  // Ports are visited in ascending order, so on a same-byte collision the
  // last non-blocking update (highest port index) wins.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (w_gnt[i] && !tcdm.wen[i] && !w_drop[i]) begin
        for (int k = 0; k < 4; k++) begin
          if (tcdm.be[i][k]) begin
            memory[w_off[i] + AW'(k)] <= tcdm.data[i][8*k +: 8];
          end
        end
      end
    end
  end

  // Responses: valid for every granted access (writes too); data holds
  // its last value on ungranted cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_rdata <= '0;
    end else begin
      for (int i = 0; i < MP; i++) begin
        r_valid[i] <= w_gnt[i];
        if (w_gnt[i]) begin
`ifdef TCDM_VERILATOR_OOB_CHECK_EN
          r_rdata[i] <= w_oob[i] ? 32'hDEAD_BEEF : w_rdata[i];
`else
          r_rdata[i] <= w_rdata[i];
`endif
        end
      end
    end
  end

  assign tcdm.gnt     = w_gnt;
  assign tcdm.r_valid = r_valid;
  assign tcdm.r_data  = r_rdata;

endmodule

// File: tb/tb_tcdm_verilator.sv
// Self-checking bench for tcdm_verilator: 3-port instance at a non-zero base
// plus a 1-port instance with a non-power-of-two size for the wrap case.
// Expected responses come from a byte-array model and are queued per port.
module tb_tcdm_verilator;

  localparam int unsigned MP    = 3;
  localparam int unsigned MSZ   = 1024;
  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int unsigned MSZ_B = 32'h30000;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic en_a;
  logic en_b;

  always #5 clk_i = ~clk_i;

  tcdm_verilator_if #(.MP(MP)) a_if ();
  tcdm_verilator_if #(.MP(1))  b_if ();

  tcdm_verilator #(.MP(MP), .MEMORY_SIZE(MSZ), .BASE_ADDR(BASE)) u_a (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (en_a),
    .tcdm     (a_if)
  );

  tcdm_verilator #(.MP(1), .MEMORY_SIZE(MSZ_B), .BASE_ADDR(32'h0)) u_b (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (en_b),
    .tcdm     (b_if)
  );

  typedef struct {
    logic        vld;
    logic        chk;
    logic [31:0] dat;
  } sb_t;

  sb_t        sb_q [MP][$];
  logic [7:0] mdl [MSZ];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned mdl_off(input logic [31:0] add);
    logic [31:0] rel;
    rel = add - BASE;
    return (rel & 32'hFFFF_FFFC) % MSZ;
  endfunction

  function automatic logic [31:0] mdl_word(input logic [31:0] add);
    int unsigned o;
    o = mdl_off(add);
    return {mdl[o+3], mdl[o+2], mdl[o+1], mdl[o]};
  endfunction

  task automatic drv(input int p, input logic rd, input logic [31:0] add,
                     input logic [3:0] be, input logic [31:0] dat);
    a_if.req[p]  = 1'b1;
    a_if.wen[p]  = rd;
    a_if.add[p]  = add;
    a_if.be[p]   = be;
    a_if.data[p] = dat;
  endtask

  task automatic idle_all();
    a_if.req  = '0;
    a_if.wen  = '1;
    a_if.add  = '0;
    a_if.be   = '0;
    a_if.data = '0;
  endtask

  // One bus cycle on instance A: check grant, queue expected responses,
  // update the model, then pop and compare after the edge.
  task automatic step(input logic do_chk);
    sb_t           e;
    logic [MP-1:0] eg;
    int unsigned   o;
    #1;
    eg = a_if.req & {MP{en_a}};
    for (int p = 0; p < MP; p++) begin
      chk_val($sformatf("gnt%0d", p), 32'(a_if.gnt[p]), 32'(eg[p]));
      e.vld = eg[p];
      e.chk = do_chk;
      e.dat = mdl_word(a_if.add[p]);
      sb_q[p].push_back(e);
    end
    for (int p = 0; p < MP; p++) begin
      if (eg[p] && !a_if.wen[p]) begin
        o = mdl_off(a_if.add[p]);
        for (int k = 0; k < 4; k++) begin
          if (a_if.be[p][k]) mdl[o+k] = a_if.data[p][8*k +: 8];
        end
      end
    end
    @(posedge clk_i);
    #1;
    for (int p = 0; p < MP; p++) begin
      e = sb_q[p].pop_front();
      chk_val($sformatf("rvalid%0d", p), 32'(a_if.r_valid[p]), 32'(e.vld));
      if (e.vld && e.chk) chk_val($sformatf("rdata%0d", p), a_if.r_data[p], e.dat);
    end
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) mdl[i] = 8'h00;
    rst_ni = 1'b0;
    en_a   = 1'b1;
    en_b   = 1'b1;
    idle_all();
    b_if.req = '0; b_if.wen = '1; b_if.add = '0; b_if.be = '0; b_if.data = '0;
    #1;
    for (int p = 0; p < MP; p++) begin
      chk_val("rst_rvalid", 32'(a_if.r_valid[p]), 32'h0);
      chk_val("rst_rdata", a_if.r_data[p], 32'h0);
    end
    #11;
    rst_ni = 1'b1;

    // Clear the array through all three ports so the model is exact.
    for (int w = 0; w < int'(MSZ / 4); w += MP) begin
      idle_all();
      for (int p = 0; p < MP; p++) begin
        if (w + p < int'(MSZ / 4)) drv(p, 1'b0, BASE + 32'((w + p) * 4), 4'hF, 32'h0);
      end
      step(1'b0);
    end

    // Preload 0x12345678 and confirm little-endian placement in memory.
    idle_all(); drv(0, 1'b0, BASE, 4'hF, 32'h1234_5678); step(1'b1);
    chk_val("mem0", 32'(u_a.memory[0]), 32'h78);
    chk_val("mem1", 32'(u_a.memory[1]), 32'h56);
    chk_val("mem2", 32'(u_a.memory[2]), 32'h34);
    chk_val("mem3", 32'(u_a.memory[3]), 32'h12);

    // Unaligned address reads the aligned word.
    idle_all(); drv(0, 1'b1, BASE + 32'h2, 4'h0, 32'h0); step(1'b1);
    chk_val("plan_read", a_if.r_data[0], 32'h1234_5678);

    // Partial write returns the pre-write word, then read merges.
    idle_all(); drv(0, 1'b0, BASE, 4'b0101, 32'hAABB_CCDD); step(1'b1);
    chk_val("wr_resp", a_if.r_data[0], 32'h1234_5678);
    idle_all(); drv(0, 1'b1, BASE, 4'h0, 32'h0); step(1'b1);
    chk_val("be_merge", a_if.r_data[0], 32'h12BB_56DD);

    // Disabled: no grant, no response, r_data holds, memory untouched.
    en_a = 1'b0;
    idle_all(); drv(0, 1'b0, BASE, 4'hF, 32'hFFFF_FFFF); step(1'b1);
    chk_val("hold_rdata", a_if.r_data[0], 32'h12BB_56DD);
    en_a = 1'b1;
    idle_all(); drv(0, 1'b1, BASE, 4'h0, 32'h0); step(1'b1);
    chk_val("en_unchanged", a_if.r_data[0], 32'h12BB_56DD);

    // Collisions: port 1 reads old word, highest port wins per byte.
    idle_all(); drv(0, 1'b0, BASE + 32'h10, 4'hF, 32'hCAFE_F00D); step(1'b1);
    idle_all();
    drv(0, 1'b0, BASE + 32'h10, 4'hF, 32'h1111_1111);
    drv(1, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    drv(2, 1'b0, BASE + 32'h10, 4'hF, 32'h2222_2222);
    step(1'b1);
    chk_val("rbw_old", a_if.r_data[1], 32'hCAFE_F00D);
    idle_all(); drv(1, 1'b1, BASE + 32'h10, 4'h0, 32'h0); step(1'b1);
    chk_val("hi_port_wins", a_if.r_data[1], 32'h2222_2222);
    idle_all();
    drv(0, 1'b0, BASE + 32'h14, 4'hF, 32'h1111_1111);
    drv(2, 1'b0, BASE + 32'h14, 4'b0011, 32'h2222_2222);
    step(1'b1);
    idle_all(); drv(2, 1'b1, BASE + 32'h14, 4'h0, 32'h0); step(1'b1);
    chk_val("byte_mix", a_if.r_data[2], 32'h1111_2222);

    // Back-to-back reads on port 1 with req held.
    for (int i = 0; i < 4; i++) begin
      idle_all(); drv(1, 1'b0, BASE + 32'h20 + 32'(4 * i), 4'hF, 32'h0A0B_0C00 + 32'(i)); step(1'b1);
    end
    idle_all();
    for (int i = 0; i < 4; i++) begin
      drv(1, 1'b1, BASE + 32'h20 + 32'(4 * i), 4'h0, 32'h0);
      step(1'b1);
      chk_val($sformatf("b2b%0d", i), a_if.r_data[1], 32'h0A0B_0C00 + 32'(i));
    end

    // Wrap on a power-of-two array: BASE+0x410 aliases offset 0x10.
    idle_all(); drv(0, 1'b1, BASE + 32'h410, 4'h0, 32'h0); step(1'b1);
    chk_val("wrap_a", a_if.r_data[0], 32'h2222_2222);

    // Non-power-of-two size: 0x140000 lands on offset 0x20000.
    idle_all();
    b_if.req = 1'b1; b_if.wen = 1'b0; b_if.add = 32'h0014_0000; b_if.be = 4'hF; b_if.data = 32'hA5A5_5A5A;
    #1;
    chk_val("b_gnt", 32'(b_if.gnt), 32'h1);
    @(posedge clk_i); #1;
    chk_val("b_wr_rvalid", 32'(b_if.r_valid), 32'h1);
    b_if.wen = 1'b1; b_if.add = 32'h0002_0000; b_if.be = 4'h0;
    chk_val("b_mem_lo", 32'(u_b.memory[32'h20000]), 32'h5A);
    chk_val("b_mem_hi", 32'(u_b.memory[32'h20003]), 32'hA5);
    @(posedge clk_i); #1;
    b_if.req = 1'b0;
    chk_val("b_rd_rvalid", 32'(b_if.r_valid), 32'h1);
    chk_val("b_wrap_rdata", b_if.r_data, 32'hA5A5_5A5A);
    @(posedge clk_i); #1;
    chk_val("b_idle_rvalid", 32'(b_if.r_valid), 32'h0);

    // Reset with a response on the outputs clears it at once.
    idle_all(); drv(0, 1'b1, BASE, 4'h0, 32'h0);
    @(posedge clk_i); #1;
    chk_val("pre_rst_rvalid", 32'(a_if.r_valid[0]), 32'h1);
    chk_val("pre_rst_rdata", a_if.r_data[0], 32'h12BB_56DD);
    idle_all();
    rst_ni = 1'b0;
    #1;
    chk_val("mid_rst_rvalid", 32'(a_if.r_valid[0]), 32'h0);
    chk_val("mid_rst_rdata", a_if.r_data[0], 32'h0);
    #2;
    rst_ni = 1'b1;
    #2;
    idle_all(); drv(0, 1'b1, BASE, 4'h0, 32'h0); step(1'b1);
    chk_val("post_rst_mem", a_if.r_data[0], 32'h12BB_56DD);

    idle_all(); step(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
